wasm_instr_loader: RTL and testbench

Upstream feeder for the instruction memory controller's write port. It accepts a byte stream of WASM code from a host link (valid/ready), packs bytes little-endian into write windows, and drives `we`, `wr_data` and `write_pointer_shift_minusone` into the controller. It holds `core_hold` high so the control unit stays idle until the image is fully written, and it flags overflow and header errors.

---
 rtl/wasm_instr_loader_pkg.sv | 36 +++
 rtl/wasm_byte_packer.sv | 42 ++++
 rtl/wasm_instr_loader.sv | 178 +++++++++++++++++
 tb/tb_wasm_instr_loader.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wasm_instr_loader_pkg.sv
// Shared definitions for the WASM instruction loader: FSM encoding, write-window sizing, header bytes.
// Window size follows the instruction-write-width / write-window-size defines unless overridden.
`ifndef WASM_INSTR_WR_WIDTH
`define WASM_INSTR_WR_WIDTH 32
`endif
`ifndef WASM_WR_WINDOW_SIZE
`define WASM_WR_WINDOW_SIZE 4
`endif

package wasm_instr_loader_pkg;

    localparam int PKG_INSTR_WR_W    = `WASM_INSTR_WR_WIDTH;
    localparam int PKG_WR_BYTES      = `WASM_WR_WINDOW_SIZE;
    localparam int PKG_LOG_WR_WINDOW = $clog2(PKG_WR_BYTES);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_COLLECT = 3'd1;
    localparam logic [2:0] ST_WRITE   = 3'd2;
    localparam logic [2:0] ST_DONE    = 3'd3;
    localparam logic [2:0] ST_ERROR   = 3'd4;

    localparam int MAGIC_LEN = 8;

    // "\0asm" followed by little-endian version 1
    function automatic logic [7:0] magic_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    magic_byte = 8'h00;
            3'd1:    magic_byte = 8'h61;
            3'd2:    magic_byte = 8'h73;
            3'd3:    magic_byte = 8'h6D;
            3'd4:    magic_byte = 8'h01;
            default: magic_byte = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/wasm_byte_packer.sv
// Packs bytes little-endian into a write window; unwritten slots stay 0x00 because the register is cleared per window.
// Shift field tracks (fill-1) as a register so it reads 0 out of reset and while empty.
module wasm_byte_packer #(
    parameter int WR_BYTES      = 4,
    parameter int LOG_WR_WINDOW = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_clr,
    input  logic                       i_push,
    input  logic [7:0]                 i_byte,
    output logic [WR_BYTES*8-1:0]      o_pack,
    output logic [LOG_WR_WINDOW:0]     o_fill,
    output logic [LOG_WR_WINDOW-1:0]   o_shift
);

    logic [WR_BYTES*8-1:0]    r_pack;
    logic [LOG_WR_WINDOW:0]   r_fill;
    logic [LOG_WR_WINDOW-1:0] r_shift;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pack  <= '0;
            r_fill  <= '0;
            r_shift <= '0;
        end else if (i_clr) begin
            r_pack  <= '0;
            r_fill  <= '0;
            r_shift <= '0;
        end else if (i_push) begin
            // push only happens while fill < WR_BYTES, so the low bits index the slot
            r_pack[{r_fill[LOG_WR_WINDOW-1:0], 3'b000} +: 8] <= i_byte;
            r_fill  <= r_fill + (LOG_WR_WINDOW+1)'(1);
            r_shift <= r_fill[LOG_WR_WINDOW-1:0];
        end
    end

    assign o_pack  = r_pack;
    assign o_fill  = r_fill;
    assign o_shift = r_shift;

endmodule

// File: rtl/wasm_instr_loader.sv
// Streams WASM code bytes into instruction-memory write windows, holding the core until the image is written.
// Optional header check: define WASM_LOADER_MAGIC_CHECK_EN to verify and strip the 8-byte magic/version.
module wasm_instr_loader
    import wasm_instr_loader_pkg::*;
#(
    parameter int WR_BYTES      = PKG_WR_BYTES,
    parameter int LOG_WR_WINDOW = PKG_LOG_WR_WINDOW,
    parameter int CAP_BYTES     = 1024,
    parameter int CNT_W         = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [7:0]               s_data,
    input  logic                     s_valid,
    input  logic                     s_last,
    output logic                     s_ready,
    input  logic                     wr_ready,
    output logic                     we,
    output logic [WR_BYTES*8-1:0]    wr_data,
    output logic [LOG_WR_WINDOW-1:0] write_pointer_shift_minusone,
    output logic                     core_hold,
    output logic                     load_done,
    output logic [CNT_W-1:0]         byte_count,
    output logic                     o_load_overflow,
    output logic                     o_magic_err
);

    logic [2:0]             r_state;
    logic                   r_s_ready, r_we, r_core_hold, r_load_done, r_ovf, r_last;
    logic [CNT_W-1:0]       r_byte_count;

    logic [2:0]             w_state_nxt;
    logic                   w_accept, w_push, w_clr, w_err_ovf, w_last_set, w_cnt_add, w_cnt_clr;
    logic                   w_at_cap, w_full_nxt;
    logic [CNT_W-1:0]       w_sum;
    logic [WR_BYTES*8-1:0]  w_pack;
    logic [LOG_WR_WINDOW:0] w_fill;
    logic [LOG_WR_WINDOW-1:0] w_shift;

`ifdef WASM_LOADER_MAGIC_CHECK_EN
    logic [3:0] r_hdr_cnt;
    logic       r_mag;
    logic       w_err_mag, w_hdr_inc;
`endif

    assign w_accept   = s_valid & r_s_ready;
    assign w_sum      = r_byte_count + CNT_W'(w_fill);
    assign w_at_cap   = (w_sum == CNT_W'(CAP_BYTES));
    assign w_full_nxt = (w_fill == (LOG_WR_WINDOW+1)'(WR_BYTES-1));

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_clr       = 1'b0;
        w_err_ovf   = 1'b0;
        w_last_set  = 1'b0;
        w_cnt_add   = 1'b0;
        w_cnt_clr   = 1'b0;
`ifdef WASM_LOADER_MAGIC_CHECK_EN
        w_err_mag   = 1'b0;
        w_hdr_inc   = 1'b0;
`endif
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_nxt = ST_COLLECT;
                    w_clr       = 1'b1;
                    w_cnt_clr   = 1'b1;
                end
            end
            ST_COLLECT: begin
                if (w_accept) begin
`ifdef WASM_LOADER_MAGIC_CHECK_EN
                    if (!r_hdr_cnt[3]) begin
                        if (s_last || (s_data != magic_byte(r_hdr_cnt[2:0]))) begin
                            w_state_nxt = ST_ERROR;
                            w_err_mag   = 1'b1;
                        end else begin
                            w_hdr_inc   = 1'b1;
                        end
                    end else
`endif
                    if (w_at_cap) begin
                        // capacity already reached: drop the byte and lock up
                        w_state_nxt = ST_ERROR;
                        w_err_ovf   = 1'b1;
                    end else begin
                        w_push     = 1'b1;
                        w_last_set = s_last;
                        if (s_last || w_full_nxt)
                            w_state_nxt = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                if (wr_ready) begin
                    w_cnt_add   = 1'b1;
                    w_clr       = 1'b1;
                    w_state_nxt = r_last ? ST_DONE : ST_COLLECT;
                end
            end
            ST_ERROR: w_state_nxt = ST_ERROR;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so each one comes straight from a flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_s_ready    <= 1'b0;
            r_we         <= 1'b0;
            r_core_hold  <= 1'b1;
            r_load_done  <= 1'b0;
            r_ovf        <= 1'b0;
            r_last       <= 1'b0;
            r_byte_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_s_ready   <= (w_state_nxt == ST_COLLECT);
            r_we        <= (w_state_nxt == ST_WRITE);
            r_core_hold <= (w_state_nxt != ST_DONE);
            r_load_done <= (w_state_nxt == ST_DONE);
            r_ovf       <= r_ovf | w_err_ovf;
            if (w_clr)
                r_last <= 1'b0;
            else if (w_last_set)
                r_last <= 1'b1;
            if (w_cnt_clr)
                r_byte_count <= '0;
            else if (w_cnt_add)
                r_byte_count <= w_sum;
        end
    end

`ifdef WASM_LOADER_MAGIC_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hdr_cnt <= '0;
            r_mag     <= 1'b0;
        end else begin
            r_mag <= r_mag | w_err_mag;
            if (w_cnt_clr)
                r_hdr_cnt <= '0;
            else if (w_hdr_inc)
                r_hdr_cnt <= r_hdr_cnt + 4'd1;
        end
    end
    assign o_magic_err = r_mag;
`else
    assign o_magic_err = 1'b0;
`endif

    wasm_byte_packer #(
        .WR_BYTES      (WR_BYTES),
        .LOG_WR_WINDOW (LOG_WR_WINDOW)
    ) u_packer (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (w_clr),
        .i_push  (w_push),
        .i_byte  (s_data),
        .o_pack  (w_pack),
        .o_fill  (w_fill),
        .o_shift (w_shift)
    );

    assign s_ready                      = r_s_ready;
    assign we                           = r_we;
    assign wr_data                      = w_pack;
    assign write_pointer_shift_minusone = w_shift;
    assign core_hold                    = r_core_hold;
    assign load_done                    = r_load_done;
    assign byte_count                   = r_byte_count;
    assign o_load_overflow              = r_ovf;

endmodule

// File: tb/tb_wasm_instr_loader.sv
// Bench for wasm_instr_loader (WR_BYTES=4, CAP_BYTES=8): directed streams, expected writes queued for a monitor.
module tb_wasm_instr_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic        wr_ready = 1'b1;
    logic        we;
    logic [31:0] wr_data;
    logic [1:0]  shift;
    logic        core_hold;
    logic        load_done;
    logic [15:0] byte_count;
    logic        ovf;
    logic        magic_err;

    typedef struct packed {
        logic [31:0] dat;
        logic [1:0]  sh;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_writes = 0;

    wasm_instr_loader #(
        .WR_BYTES(4), .LOG_WR_WINDOW(2), .CAP_BYTES(8), .CNT_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .wr_ready(wr_ready), .we(we), .wr_data(wr_data),
        .write_pointer_shift_minusone(shift),
        .core_hold(core_hold), .load_done(load_done), .byte_count(byte_count),
        .o_load_overflow(ovf), .o_magic_err(magic_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, req);
        end
    endtask

    // Monitor: a write completes at the next posedge whenever we & wr_ready hold at the negedge
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && we && wr_ready) begin
                n_writes++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", wr_data, 32'h0);
                    checks++;
                    errors++;
                    $display("FAIL write_without_expectation actual %h required none", wr_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("wr_data", wr_data, e.dat);
                    chk("shift", {30'd0, shift}, {30'd0, e.sh});
                end
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        forever begin
            @(negedge clk);
            if (s_ready) break;
            n++;
            if (n > 60) begin
                checks++;
                errors++;
                $display("FAIL send_timeout actual s_ready=0 required 1 byte %h", d);
                break;
            end
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_hdr();
`ifdef WASM_LOADER_MAGIC_CHECK_EN
        logic [7:0] hdr [8];
        hdr = '{8'h00, 8'h61, 8'h73, 8'h6D, 8'h01, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 8; i++) send_byte(hdr[i], 1'b0);
`endif
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (load_done) break;
            n++;
            if (n > 100) begin
                checks++;
                errors++;
                $display("FAIL %s timeout actual load_done=0 required 1", name);
                break;
            end
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_s_ready"},   {31'd0, s_ready},   32'd0);
        chk({tag, "_we"},        {31'd0, we},        32'd0);
        chk({tag, "_wr_data"},   wr_data,            32'd0);
        chk({tag, "_shift"},     {30'd0, shift},     32'd0);
        chk({tag, "_core_hold"}, {31'd0, core_hold}, 32'd1);
        chk({tag, "_load_done"}, {31'd0, load_done}, 32'd0);
        chk({tag, "_count"},     {16'd0, byte_count}, 32'd0);
        chk({tag, "_ovf"},       {31'd0, ovf},       32'd0);
        chk({tag, "_magic"},     {31'd0, magic_err}, 32'd0);
    endtask

    initial begin
        int wbase;
        // Reset state
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Partial window: 01..06, last on 06
        wr_ready = 1'b1;
        pulse_start();
        @(negedge clk);
        chk("s_ready_after_start", {31'd0, s_ready}, 32'd1);
        @(posedge clk); #1;
        send_hdr();
        exp_q.push_back('{32'h04030201, 2'd3});
        exp_q.push_back('{32'h00000605, 2'd1});
        for (int i = 1; i <= 6; i++) send_byte(8'(i), i == 6);
        wait_done("partial");
        chk("partial_count", {16'd0, byte_count}, 32'd6);
        chk("partial_core_hold", {31'd0, core_hold}, 32'd0);
        chk("partial_writes", n_writes, 32'd2);

        // Reload from DONE, with write backpressure and s_last on a full window
        @(posedge clk); #1;
        pulse_start();
        @(negedge clk);
        chk("reload_core_hold", {31'd0, core_hold}, 32'd1);
        chk("reload_count", {16'd0, byte_count}, 32'd0);
        chk("reload_load_done", {31'd0, load_done}, 32'd0);
        @(posedge clk); #1;
        send_hdr();
        wr_ready = 1'b0;
        wbase = n_writes;
        exp_q.push_back('{32'h44332211, 2'd3});
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_we", {31'd0, we}, 32'd1);
            chk("bp_wr_data", wr_data, 32'h44332211);
            chk("bp_s_ready", {31'd0, s_ready}, 32'd0);
        end
        @(posedge clk); #1;
        wr_ready = 1'b1;
        wait_done("backpressure");
        chk("bp_writes", n_writes - wbase, 32'd1);
        chk("bp_count", {16'd0, byte_count}, 32'd4);

        // Reset mid-load after 3 bytes
        @(posedge clk); #1;
        pulse_start();
        send_hdr();
        send_byte(8'hA1, 1'b0);
        send_byte(8'hA2, 1'b0);
        send_byte(8'hA3, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_vals("midreset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        wbase = n_writes;
        pulse_start();
        send_hdr();
        exp_q.push_back('{32'h0D0C0B0A, 2'd3});
        for (int i = 0; i < 4; i++) send_byte(8'h0A + 8'(i), i == 3);
        wait_done("after_reset");
        chk("after_reset_writes", n_writes - wbase, 32'd1);
        chk("after_reset_count", {16'd0, byte_count}, 32'd4);

`ifdef WASM_LOADER_MAGIC_CHECK_EN
        // Valid header then AA BB CC DD
        @(posedge clk); #1;
        pulse_start();
        send_hdr();
        exp_q.push_back('{32'hDDCCBBAA, 2'd3});
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b0);
        send_byte(8'hDD, 1'b1);
        wait_done("magic_ok");
        chk("magic_ok_count", {16'd0, byte_count}, 32'd4);
        chk("magic_ok_err", {31'd0, magic_err}, 32'd0);

        // Header byte 2 corrupted
        @(posedge clk); #1;
        wbase = n_writes;
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h61, 1'b0);
        send_byte(8'h72, 1'b0);
        repeat (4) @(negedge clk);
        chk("magic_bad_err", {31'd0, magic_err}, 32'd1);
        chk("magic_bad_we", {31'd0, we}, 32'd0);
        chk("magic_bad_s_ready", {31'd0, s_ready}, 32'd0);
        chk("magic_bad_writes", n_writes - wbase, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
`else
        chk("magic_tied_low", {31'd0, magic_err}, 32'd0);
`endif

        // Overflow: capacity 8, stream 9 bytes
        @(posedge clk); #1;
        wbase = n_writes;
        pulse_start();
        send_hdr();
        exp_q.push_back('{32'h04030201, 2'd3});
        exp_q.push_back('{32'h08070605, 2'd3});
        for (int i = 1; i <= 9; i++) send_byte(8'(i), 1'b0);
        @(negedge clk);
        chk("ovf_flag", {31'd0, ovf}, 32'd1);
        chk("ovf_s_ready", {31'd0, s_ready}, 32'd0);
        chk("ovf_core_hold", {31'd0, core_hold}, 32'd1);
        chk("ovf_count", {16'd0, byte_count}, 32'd8);
        chk("ovf_load_done", {31'd0, load_done}, 32'd0);
        @(posedge clk); #1;
        pulse_start();
        repeat (4) @(negedge clk);
        chk("ovf_start_ignored", {31'd0, s_ready}, 32'd0);
        chk("ovf_we", {31'd0, we}, 32'd0);
        chk("ovf_writes", n_writes - wbase, 32'd2);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
